// File: rtl/zero_scan_arb_pkg.sv
// zero_scan_arb_pkg: shared constants, state encoding and round-robin helper
package zero_scan_arb_pkg;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;
    // first requesting index at or after p, wrapping 3->0
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] c;
        rr_pick = p;
        for (int k = 3; k >= 0; k--) begin
            c = p + 2'(k);
            if (r[c]) rr_pick = c;
        end
    endfunction
endpackage

// File: rtl/zero_scan_arb_norgate.sv
// norgate: all-zero detector (NOR reduction of a word)
module norgate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    output logic             out
);
    assign out = ~|in;
endmodule

// File: rtl/zero_scan_arb.sv
// zero_scan_arb: round-robin arbiter feeding one shared all-zero detector
module zero_scan_arb
    import zero_scan_arb_pkg::*;
#(
    parameter int WIDTH = zero_scan_arb_pkg::WIDTH,
    parameter int NREQ  = zero_scan_arb_pkg::NREQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   din,
    output logic [NREQ-1:0]         gnt,
    output logic                    valid,
    output logic                    zero,
    output logic [1:0]              id,
    output logic [CNT_W-1:0]        zero_cnt
);
    state_t             state;
    logic [1:0]         ptr;
    logic [1:0]         gidx;
    logic [1:0]         pick;
    logic [WIDTH-1:0]   cap;
    logic               nz;

    assign pick = rr_pick(req, ptr);

    norgate #(.WIDTH(WIDTH)) u_nor (.in(cap), .out(nz));

    // grant / capture / evaluate / release sequence with saturating zero counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            gnt      <= '0;
            valid    <= 1'b0;
            zero     <= 1'b0;
            id       <= '0;
            zero_cnt <= '0;
            cap      <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gnt   <= NREQ'(1) << pick;
                    cap   <= din[pick*WIDTH +: WIDTH];
                    gidx  <= pick;
                    state <= EVAL;
                end
                EVAL: begin
                    zero     <= nz;
                    valid    <= 1'b1;
                    id       <= gidx;
                    zero_cnt <= (nz && zero_cnt != '1) ? zero_cnt + 1'b1 : zero_cnt;
                    state    <= DONE;
                end
                DONE: begin
                    valid <= 1'b0;
                    zero  <= 1'b0;
                    id    <= '0;
                    gnt   <= '0;
                    ptr   <= gidx + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zero_scan_arb.sv
// tb_zero_scan_arb: table vectors, corner sequences and random traffic vs a transaction model
module tb_zero_scan_arb;
    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        logic [3:0]     req;
        logic [N*W-1:0] din;
        int             eid;
        logic           ez;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic [N-1:0]     gnt;
    logic             valid;
    logic             zero;
    logic [1:0]       id;
    logic [15:0]      zero_cnt;

    int pass_cnt = 0;
    int total    = 0;

    int         m_busy = 0;
    int         m_win  = 0;
    int         m_ptr  = 0;
    int         m_cnt  = 0;
    logic [W-1:0] m_word = '0;

    vec_t tbl[6];
    int   ids[$];
    int   cyc[$];

    always #5 clk = ~clk;

    zero_scan_arb dut (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt), .valid(valid), .zero(zero), .id(id), .zero_cnt(zero_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int pick_model(input logic [3:0] r, input int p);
        for (int j = 0; j < N; j++)
            if (r[(p + j) % N]) return (p + j) % N;
        return 0;
    endfunction

    // one clock: advance the transaction model at the edge, compare at the falling edge
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else if (m_busy == 0) begin
            if (req != 0) begin
                m_win  = pick_model(req, m_ptr);
                m_word = din[m_win*W +: W];
                m_busy = 1;
            end
        end else if (m_busy == 1) begin
            if (m_word == 0 && m_cnt < 65535) m_cnt++;
            m_busy = 2;
        end else begin
            m_ptr  = (m_win + 1) % N;
            m_busy = 0;
        end
        @(negedge clk);
        check("gnt",      32'(gnt),      m_busy != 0 ? 32'(1 << m_win) : 32'd0);
        check("valid",    32'(valid),    32'(m_busy == 2));
        check("zero",     32'(zero),     32'(m_busy == 2 && m_word == 0));
        check("id",       32'(id),       m_busy == 2 ? 32'(m_win) : 32'd0);
        check("zero_cnt", 32'(zero_cnt), 32'(m_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h0},               0, 1'b1};
        tbl[1] = '{4'b0100, {32'h0, 32'h01000100, 32'h0, 32'h0},        2, 1'b0};
        tbl[2] = '{4'b0011, {32'h0, 32'h0, 32'h5, 32'h0},               0, 1'b1};
        tbl[3] = '{4'b1001, {32'h0, 32'h0, 32'h0, 32'hFF},              3, 1'b1};
        tbl[4] = '{4'b0110, {32'h0, 32'h7, 32'h0, 32'h0},               1, 1'b1};
        tbl[5] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h80000000},        0, 1'b0};

        rst = 1'b1;
        req = '0;
        din = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // table vectors; din is inverted right after the grant edge to prove capture
        foreach (tbl[t]) begin
            req = tbl[t].req;
            din = tbl[t].din;
            step();
            req = '0;
            din = ~tbl[t].din;
            step();
            check("tbl_valid", 32'(valid), 32'd1);
            check("tbl_id",    32'(id),    32'(tbl[t].eid));
            check("tbl_zero",  32'(zero),  32'(tbl[t].ez));
            step();
        end
        check("tbl_cnt", 32'(zero_cnt), 32'd4);

        // fairness: all four requesting with zero words
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        din = '0;
        for (int c = 0; c < 30 && ids.size() < 5; c++) begin
            step();
            if (valid) begin
                ids.push_back(int'(id));
                cyc.push_back(c);
            end
        end
        req = '0;
        step();
        step();
        check("fair_count", 32'(ids.size()), 32'd5);
        foreach (ids[i]) check("fair_id", 32'(ids[i]), 32'(i % N));
        for (int i = 1; i < cyc.size(); i++) check("fair_gap", 32'(cyc[i] - cyc[i-1]), 32'd3);
        check("fair_cnt", 32'(zero_cnt), 32'd5);

        // reset during EVAL abandons the transaction and rewinds the pointer
        req = 4'b0001;
        din = '0;
        step();
        rst = 1'b1;
        req = '0;
        step();
        check("rst_valid", 32'(valid),    32'd0);
        check("rst_cnt",   32'(zero_cnt), 32'd0);
        rst = 1'b0;
        step();
        check("rst_novalid", 32'(valid), 32'd0);
        req = 4'b1001;
        step();
        check("rst_regrant", 32'(gnt), 32'b0001);
        req = '0;
        step();
        step();

        // saturation from near the top of the counter
        force dut.zero_cnt = 16'hFFFD;
        #1;
        release dut.zero_cnt;
        m_cnt = 65533;
        req = 4'b0001;
        din = '0;
        repeat (9) step();
        req = '0;
        check("sat_cnt", 32'(zero_cnt), 32'hFFFF);
        step();
        step();

        // random traffic against the model
        repeat (400) begin
            rst = ($urandom_range(0, 63) == 0);
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                din[i*W +: W] = ($urandom_range(0, 1) == 1) ? 32'h0 : 32'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
